fp_div_ctrl: RTL and testbench
==============================

Name: fp_div_ctrl

Overview:
- Sequencing controller for the shared 32-bit IEEE-754 iterative restoring divider (48-iteration, active-low async reset, `enable` high when iteration count reaches zero).
- Accepts a division request over a start/done handshake and latches the operands.
- Restarts the divider, waits for completion with a watchdog, then registers the result and flags.
- Special operands (NaN, Inf, zero, denormal) bypass the divider entirely and resolve in one cycle.

Parameters:
- ITER, 48, divider iteration count; the divider's internal count reset value.
- TIMEOUT, 64, maximum cycles spent in RUN before aborting with `err`; must be greater than ITER.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- A_in  input  32  dividend, IEEE-754 single.
- B_in  input  32  divisor, IEEE-754 single.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result and flags valid in the same cycle.
- result  output  32  quotient, held until the next done.
- overflow  output  1  from divider, registered.
- underflow  output  1  from divider, registered.
- invalid  output  1  NaN operand, 0/0 or Inf/Inf.
- div_zero  output  1  finite nonzero / zero.
- err  output  1  watchdog expired in RUN.
- div_A  output  32  divider dividend, registered.
- div_B  output  32  divider divisor, registered.
- div_rst_n  output  1  divider reset, active-low, registered.
- div_result  input  32  divider quotient.
- div_overflow  input  1  divider overflow.
- div_underflow  input  1  divider underflow.
- div_enable  input  1  divider completion (count == 0).

Behaviour:
- Reset (RST=1, asynchronous):
  - State goes to IDLE.
  - All outputs become 0, including div_rst_n=0, so the divider is held in reset.
  - Watchdog counter cleared.
  - Reset mid-operation abandons the request with no done pulse.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - div_rst_n=1.
  - On start=1: latch A_in/B_in into div_A/div_B and classify the operands.
  - Special operand: go directly to DONE with the bypass result.
  - Otherwise: go to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle; div_rst_n=0.
  - Next state RUN; div_rst_n=1 from the RUN entry edge.
- RUN:
  - Watchdog increments each cycle.
  - If div_enable=1: capture div_result/div_overflow/div_underflow, set invalid=div_zero=err=0, go to DONE.
  - Else if watchdog==TIMEOUT-1: result=32'h7FC00000, err=1, go to DONE.
  - Ignore div_enable in the first RUN cycle, as protection against a stale level.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - result and flags hold until the next DONE.
- Latency, start edge to done cycle:
  - Normal path: ITER+3 cycles, i.e. 51 at the default.
  - Bypass path: 1 cycle.
- start while busy: ignored, not queued. start in the DONE cycle is also ignored.
- Operand classification:
  - NaN: exp==255 and frac!=0.
  - Inf: exp==255 and frac==0.
  - Zero: exp==0; denormals are flushed to zero.
  - Sign is the XOR of the operand signs.
- Bypass priority, highest first:
  1. Either NaN, 0/0, or Inf/Inf: 7FC00000, invalid=1.
  2. A Inf: signed Inf.
  3. B zero: signed Inf, div_zero=1.
  4. A zero or B Inf: signed zero.
- Bypass results force overflow=underflow=err=0.
- Flags from the previous operation are overwritten at every DONE.

Test Plan:
- 6.0 (40C00000) / 2.0 (40000000):
  - done exactly 51 cycles after start, result 40400000.
  - busy high for those cycles; div_rst_n low for exactly one cycle.
- 1.0 / 0.0 (3F800000 / 00000000):
  - done 1 cycle after start, result 7F800000, div_zero=1.
  - div_rst_n never pulses.
- Special-operand bypass:
  - 0/0 -> 7FC00000 invalid=1.
  - -Inf (FF800000) / 2.0 -> FF800000.
  - 1.0 / Inf -> 00000000.
  - 7FC00001 / 1.0 -> 7FC00000 invalid=1.
- start pulsed again at cycle 20 of a normal operation:
  - Ignored; single done at cycle 51.
  - div_A/div_B unchanged.
- Divider model with div_enable stuck low:
  - err=1 and result 7FC00000 after TIMEOUT cycles in RUN.
  - Controller returns to IDLE and accepts the next request.
- RST asserted at cycle 30 of RUN:
  - All outputs 0 immediately; no done pulse.
  - A new request after release completes normally in 51 cycles.

Source files
------------

// File: rtl/fp_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_ctrl
// Brief    : Start/done sequencer for the shared iterative IEEE-754 divider,
//            with special-operand bypass and a RUN-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_ctrl #(
    parameter int ITER    = 48,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid,
    output logic        div_zero,
    output logic        err,
    output logic [31:0] div_A,
    output logic [31:0] div_B,
    output logic        div_rst_n,
    input  logic [31:0] div_result,
    input  logic        div_overflow,
    input  logic        div_underflow,
    input  logic        div_enable
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    // Watchdog is wide enough for whichever of TIMEOUT / ITER is larger.
    localparam int c_WD_MAX = (TIMEOUT > ITER) ? TIMEOUT : ITER + 1;
    localparam int c_WD_W   = $clog2(c_WD_MAX + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [c_WD_W-1:0] r_wd;
    logic              r_done;
    logic [31:0]       r_result;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_invalid;
    logic              r_div_zero;
    logic              r_err;
    logic [31:0]       r_div_a;
    logic [31:0]       r_div_b;
    logic              r_div_rst_n;

    logic        w_a_nan;
    logic        w_a_inf;
    logic        w_a_zero;
    logic        w_b_nan;
    logic        w_b_inf;
    logic        w_b_zero;
    logic        w_sign;
    logic        w_special;
    logic [31:0] w_byp_result;
    logic        w_byp_invalid;
    logic        w_byp_div_zero;

    // Denormals have exp==0 and are treated as zero.
    assign w_a_nan  = (&A_in[30:23]) &  (|A_in[22:0]);
    assign w_a_inf  = (&A_in[30:23]) & ~(|A_in[22:0]);
    assign w_a_zero = ~(|A_in[30:23]);
    assign w_b_nan  = (&B_in[30:23]) &  (|B_in[22:0]);
    assign w_b_inf  = (&B_in[30:23]) & ~(|B_in[22:0]);
    assign w_b_zero = ~(|B_in[30:23]);
    assign w_sign   = A_in[31] ^ B_in[31];

    always_comb begin
        w_special      = 1'b1;
        w_byp_result   = 32'h0000_0000;
        w_byp_invalid  = 1'b0;
        w_byp_div_zero = 1'b0;
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
            w_byp_result  = c_QNAN;
            w_byp_invalid = 1'b1;
        end else if (w_a_inf) begin
            w_byp_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_byp_result   = {w_sign, 8'hFF, 23'd0};
            w_byp_div_zero = 1'b1;
        end else if (w_a_zero | w_b_inf) begin
            w_byp_result = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_done      <= 1'b0;
            r_result    <= 32'h0000_0000;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
            r_div_zero  <= 1'b0;
            r_err       <= 1'b0;
            r_div_a     <= 32'h0000_0000;
            r_div_b     <= 32'h0000_0000;
            r_div_rst_n <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_div_rst_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div_a <= A_in;
                        r_div_b <= B_in;
                        if (w_special) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_result    <= w_byp_result;
                            r_overflow  <= 1'b0;
                            r_underflow <= 1'b0;
                            r_invalid   <= w_byp_invalid;
                            r_div_zero  <= w_byp_div_zero;
                            r_err       <= 1'b0;
                        end else begin
                            r_state     <= S_CLEAR;
                            r_div_rst_n <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_RUN;
                    r_wd    <= '0;
                end
                S_RUN: begin
                    r_wd <= r_wd + c_WD_W'(1);
                    // A high div_enable on the first RUN cycle may be left
                    // over from before the divider was restarted.
                    if (div_enable && (r_wd != '0)) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_result    <= div_result;
                        r_overflow  <= div_overflow;
                        r_underflow <= div_underflow;
                        r_invalid   <= 1'b0;
                        r_div_zero  <= 1'b0;
                        r_err       <= 1'b0;
                    end else if (r_wd == c_WD_LAST) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_result    <= c_QNAN;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_invalid   <= 1'b0;
                        r_div_zero  <= 1'b0;
                        r_err       <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign invalid   = r_invalid;
    assign div_zero  = r_div_zero;
    assign err       = r_err;
    assign div_A     = r_div_a;
    assign div_B     = r_div_b;
    assign div_rst_n = r_div_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_ctrl
// Brief    : Self-checking bench for fp_div_ctrl with a divider stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_ctrl;

    localparam int ITER    = 48;
    localparam int TIMEOUT = 64;

    logic        CLK;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A_in = 32'h0;
    logic [31:0] B_in = 32'h0;
    logic        busy, done, overflow, underflow, invalid, div_zero, err;
    logic [31:0] result, div_A, div_B;
    logic        div_rst_n;
    logic [31:0] div_result;
    logic        div_overflow, div_underflow, div_enable;

    logic stuck = 1'b0;
    logic stale = 1'b0;
    int   dcnt;

    fp_div_ctrl #(.ITER(ITER), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .A_in(A_in), .B_in(B_in),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .underflow(underflow), .invalid(invalid), .div_zero(div_zero), .err(err),
        .div_A(div_A), .div_B(div_B), .div_rst_n(div_rst_n),
        .div_result(div_result), .div_overflow(div_overflow),
        .div_underflow(div_underflow), .div_enable(div_enable)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stand-in quotient: exact for 6/2, an arbitrary mix otherwise.
    function automatic logic [31:0] dq(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge CLK or negedge div_rst_n) begin
        if (!div_rst_n) dcnt <= ITER;
        else if (dcnt != 0) dcnt <= dcnt - 1;
    end
    assign div_enable    = !stuck && ((dcnt == 0) || (stale && dcnt == ITER));
    assign div_result    = dq(div_A, div_B);
    assign div_overflow  = div_A[0] ^ div_B[1];
    assign div_underflow = div_A[2] & div_B[3];

    typedef struct packed {
        logic        special;
        logic [31:0] res;
        logic [4:0]  flags;   // {overflow, underflow, invalid, div_zero, err}
    } exp_t;

    localparam int K_FIN = 0, K_ZERO = 1, K_INF = 2, K_NAN = 3;

    function automatic int kind(input logic [31:0] x);
        if (x[30:23] == 8'd0) return K_ZERO;
        if (x[30:23] != 8'hFF) return K_FIN;
        return (x[22:0] == 23'd0) ? K_INF : K_NAN;
    endfunction

    function automatic exp_t predict(input logic [31:0] a, input logic [31:0] b, input logic st);
        exp_t e;
        int ka = kind(a);
        int kb = kind(b);
        logic s = a[31] ^ b[31];
        e.special = 1'b1;
        e.flags   = 5'b0;
        if (ka == K_NAN || kb == K_NAN || (ka == kb && (ka == K_ZERO || ka == K_INF))) begin
            e.res = 32'h7FC0_0000; e.flags = 5'b00100;
        end else if (ka == K_INF) begin
            e.res = {s, 31'h7F80_0000};
        end else if (kb == K_ZERO) begin
            e.res = {s, 31'h7F80_0000}; e.flags = 5'b00010;
        end else if (ka == K_ZERO || kb == K_INF) begin
            e.res = {s, 31'd0};
        end else begin
            e.special = 1'b0;
            if (st) begin
                e.res = 32'h7FC0_0000; e.flags = 5'b00001;
            end else begin
                e.res   = dq(a, b);
                e.flags = {a[0] ^ b[1], a[2] & b[3], 3'b000};
            end
        end
        return e;
    endfunction

    int errors = 0;
    int checks = 0;
    int ncyc = 0;
    int t0 = 0;
    int lat = 0;
    logic active = 1'b0;
    logic normal = 1'b0;
    logic in_reset = 1'b1;
    logic [31:0] ea = 0, eb = 0, er = 0, hr = 0;
    logic [4:0]  ef = 0, hf = 0;
    int last_done_n = -1;
    int rstn_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Per-cycle comparison against the transaction-level expectation.
    initial begin : compare
        int n;
        forever begin
            @(negedge CLK);
            ncyc++;
            if (in_reset) begin
                chk("rst busy", {31'd0, busy}, 0);
                chk("rst done", {31'd0, done}, 0);
                chk("rst div_rst_n", {31'd0, div_rst_n}, 0);
                chk("rst result", result, 0);
                chk("rst flags", {27'd0, overflow, underflow, invalid, div_zero, err}, 0);
                chk("rst div_A", div_A, 0);
                chk("rst div_B", div_B, 0);
            end else begin
                n = ncyc - t0;
                if (active && done === 1'b1) last_done_n = n;
                if (active && div_rst_n === 1'b0) rstn_low++;
                chk("busy", {31'd0, busy}, {31'd0, active && n >= 1 && n <= lat});
                chk("done", {31'd0, done}, {31'd0, active && n == lat});
                chk("div_rst_n", {31'd0, div_rst_n}, {31'd0, !(active && normal && n == 1)});
                if (active && n == lat) begin
                    hr = er;
                    hf = ef;
                end
                chk("result", result, hr);
                chk("flags", {27'd0, overflow, underflow, invalid, div_zero, err}, {27'd0, hf});
                if (active && n >= 1) begin
                    chk("div_A", div_A, ea);
                    chk("div_B", div_B, eb);
                end
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic st,
                         input logic sl, input int extra, input int rst_at);
        exp_t e = predict(a, b, st);
        int n;
        @(negedge CLK); #1;
        stuck = st; stale = sl;
        A_in = a; B_in = b; start = 1'b1;
        t0 = ncyc; ea = a; eb = b; er = e.res; ef = e.flags;
        normal = !e.special;
        lat = e.special ? 1 : (st ? TIMEOUT + 2 : ITER + 3);
        last_done_n = -1; rstn_low = 0;
        active = 1'b1;
        forever begin
            @(negedge CLK); #1;
            n = ncyc - t0;
            start = (n == extra);
            A_in = $urandom; B_in = $urandom;
            if (n == rst_at) begin
                RST = 1'b1;
                #1;
                chk("async rst busy", {31'd0, busy}, 0);
                chk("async rst result", result, 0);
                chk("async rst div_A", div_A, 0);
                active = 1'b0; in_reset = 1'b1; hr = 0; hf = 0;
                @(negedge CLK); #1;
                RST = 1'b0; in_reset = 1'b0; start = 1'b0;
                return;
            end
            if (n >= lat) break;
        end
        @(negedge CLK); #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 9);
        case (k)
            0: r[30:23] = 8'd0;
            1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    initial begin : global_guard
        #900000;
        $display("FAIL global timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0; in_reset = 1'b0;

        chk("model 6/2", predict(32'h40C0_0000, 32'h4000_0000, 1'b0).res, 32'h4040_0000);
        chk("model 1/0", predict(32'h3F80_0000, 32'h0000_0000, 1'b0).res, 32'h7F80_0000);
        chk("model 1/0 dz", {27'd0, predict(32'h3F80_0000, 32'h0, 1'b0).flags}, 5'b00010);
        chk("model 0/0", predict(32'h0, 32'h0, 1'b0).res, 32'h7FC0_0000);
        chk("model -inf/2", predict(32'hFF80_0000, 32'h4000_0000, 1'b0).res, 32'hFF80_0000);
        chk("model 1/inf", predict(32'h3F80_0000, 32'h7F80_0000, 1'b0).res, 32'h0000_0000);
        chk("model nan inv", {27'd0, predict(32'h7FC0_0001, 32'h3F80_0000, 1'b0).flags}, 5'b00100);

        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 1'b0, 20, -1);
        chk("6/2 latency", last_done_n, 51);
        chk("6/2 rst pulse", rstn_low, 1);
        chk("6/2 result", result, 32'h4040_0000);

        do_op(32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, -1, -1);
        chk("1/0 latency", last_done_n, 1);
        chk("1/0 rst pulse", rstn_low, 0);
        chk("1/0 div_zero", {31'd0, div_zero}, 1);

        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, -1);
        chk("0/0 invalid", {31'd0, invalid}, 1);
        do_op(32'hFF80_0000, 32'h4000_0000, 1'b0, 1'b0, -1, -1);
        chk("-inf/2 result", result, 32'hFF80_0000);
        do_op(32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0, -1, -1);
        chk("1/inf result", result, 32'h0000_0000);
        do_op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b0, -1, -1);
        chk("nan result", result, 32'h7FC0_0000);

        do_op(32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b0, -1, -1);
        chk("timeout latency", last_done_n, TIMEOUT + 2);
        chk("timeout err", {31'd0, err}, 1);
        chk("timeout result", result, 32'h7FC0_0000);
        do_op(32'h3FC0_0000, 32'h4080_0000, 1'b0, 1'b1, -1, -1);
        chk("after timeout latency", last_done_n, 51);

        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 1'b0, -1, 31);
        chk("reset no done", last_done_n, -1);
        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 1'b0, -1, -1);
        chk("post reset latency", last_done_n, 51);
        chk("post reset result", result, 32'h4040_0000);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = rnd_fp();
            logic [31:0] b = rnd_fp();
            logic st = ($urandom_range(0, 9) == 0);
            logic sl = ($urandom_range(0, 3) == 0);
            int ex = int'($urandom_range(0, 70));
            do_op(a, b, st, sl, ex, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
